ofm_tile_drain: RTL
===================

Name: ofm_tile_drain

Overview:
- Sits directly downstream of the 256-PE convolution array.
- Captures the full 256-lane OFM vector when a tile's accumulation completes.
- Holds it in one of two ping-pong banks, so the array can restart on the next tile while the previous one drains.
- Serializes each tile onto a narrow valid/ready byte-lane stream toward the OFM writeback path.

Parameters:
- NUM_OF_PE, 256, PE lanes per tile; must be a multiple of OUT_LANES.
- DATA_W, 8, bits per PE output.
- OUT_LANES, 4, PE outputs per output beat.
- NUM_TILES, 4, tiles per job (1024-pixel channel / 256 PEs).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sync job start; clears all state.
- ofm_in  in  NUM_OF_PE*DATA_W  array OFM; lane m at [m*DATA_W +: DATA_W].
- ofm_load  in  1  1-cycle strobe; ofm_in is final for the current tile.
- load_ready  out  1  a free bank exists for the next ofm_load.
- out_data  out  OUT_LANES*DATA_W  beat payload.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  last beat of the current tile.
- out_tile_idx  out  max(1,$clog2(NUM_TILES))  tile number of the beat being presented.
- job_done  out  1  1-cycle pulse after the last beat of tile NUM_TILES-1.
- overflow_err  out  1  sticky: ofm_load seen with no free bank.

Behaviour:
- Reset (async, while rst=1):
  - banks empty, wr_sel=0, rd_sel=0, beat=0, tile=0.
  - out_valid=0, out_last=0, out_data=0, out_tile_idx=0, job_done=0, overflow_err=0.
  - load_ready=1.
  - Bank contents need not be cleared.
- State per bank: full flag plus NUM_OF_PE*DATA_W storage.
- load_ready = ~full[wr_sel], from registered state only; no bypass.
- Capture: on an edge with ofm_load=1 and load_ready=1:
  - copy ofm_in into bank wr_sel;
  - set full[wr_sel];
  - toggle wr_sel.
- ofm_load with load_ready=0: data dropped, banks untouched, overflow_err set to 1 until rst or start.
- Read FSM, two states:
  - IDLE: out_valid=0. Moves to STREAM when full[rd_sel]=1.
  - STREAM: out_valid=1.
- Latency: out_valid is high in the cycle immediately after the capturing edge, when the read side is idle.
- Beat b (0..NUM_OF_PE/OUT_LANES-1) carries lanes b*OUT_LANES .. b*OUT_LANES+OUT_LANES-1, lowest lane in the LSBs.
- out_last=1 only on beat NUM_OF_PE/OUT_LANES-1.
- out_tile_idx = tile counter.
- A transfer occurs on an edge with out_valid & out_ready. Otherwise out_data, out_last and out_tile_idx are held stable; out_valid never drops without a transfer, except on start or rst.
- On a transfer of a non-last beat: beat+1.
- On the transfer of the last beat:
  - clear full[rd_sel], toggle rd_sel, beat=0;
  - tile+1, wrapping to 0 after NUM_TILES-1;
  - if the tile was NUM_TILES-1, job_done=1 for the next cycle;
  - the FSM goes to STREAM if the other bank is full, else IDLE.
  - No bubble between tiles when the next bank is already full.
- Simultaneous events:
  - Capture into one bank and release of the other on the same edge: both take effect.
  - Release of bank wr_sel on the same edge as an ofm_load: the load is rejected, because load_ready was 0, and overflow_err is set.
- start (synchronous, highest priority):
  - same effect as reset on all state;
  - an ofm_load on the same edge is ignored without setting overflow_err;
  - start mid-stream aborts the current tile; no job_done.
- rst mid-stream: immediate return to the reset state; no partial beats after release.

Test Plan:
- Single tile, out_ready=1, ofm_in lane m = m[7:0], ofm_load pulse:
  - out_valid=1 in the next cycle;
  - 64 beats, beat0 = 32'h03020100, beat63 = 32'hFFFEFDFC;
  - out_last only on beat63, out_tile_idx=0;
  - load_ready stays 1.
- Backpressure: random out_ready with ~40% duty:
  - out_data, out_last and out_tile_idx are held while out_valid=1 and out_ready=0;
  - the 64-beat sequence is identical to the previous case.
- Ping-pong:
  - With out_ready=0, issue loads A (lanes=8'hA0) and B (lanes=8'hB1): load_ready=0 after B.
  - A third load C produces overflow_err=1, and the stream is 64 beats of A0 then 64 of B1 (no C) once out_ready=1.
- Full job, 4 tiles loaded back-to-back, out_ready=1:
  - out_tile_idx is 0,1,2,3 with no gaps;
  - job_done pulses exactly once, the cycle after tile 3 beat63;
  - the tile counter is back at 0.
- Reset/start mid-stream:
  - rst at beat 20 of tile 1: out_valid=0 and load_ready=1 immediately, overflow_err cleared.
  - start at beat 20 has the same result at the next edge, with no job_done.
  - A following load streams from beat0 with out_tile_idx=0.

Source files
------------

// File: rtl/ofm_tile_drain.sv
// Ping-pong capture of the 256-lane OFM vector and byte-lane serialization
// onto a valid/ready stream toward the OFM writeback path.
module ofm_tile_drain #(
   parameter int NUM_OF_PE = 256,
   parameter int DATA_W    = 8,
   parameter int OUT_LANES = 4,
   parameter int NUM_TILES = 4
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                start,
   input  logic [NUM_OF_PE*DATA_W-1:0]                         ofm_in,
   input  logic                                                ofm_load,
   output logic                                                load_ready,
   output logic [OUT_LANES*DATA_W-1:0]                         out_data,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic                                                out_last,
   output logic [((NUM_TILES > 1) ? $clog2(NUM_TILES) : 1)-1:0] out_tile_idx,
   output logic                                                job_done,
   output logic                                                overflow_err
);

   localparam int OUT_W  = OUT_LANES * DATA_W;
   localparam int BEATS  = NUM_OF_PE / OUT_LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

   typedef enum logic {ST_IDLE, ST_STREAM} state_t;

   state_t                      r_state, w_state_nxt;
   logic [BEATS-1:0][OUT_W-1:0] r_bank [2];
   logic [1:0]                  r_full, w_full_cap, w_full_nxt;
   logic                        r_wr_sel, r_rd_sel;
   logic [BEAT_W-1:0]           r_beat;
   logic [TILE_W-1:0]           r_tile;
   logic                        r_job_done, r_overflow_err;
   logic                        w_capture, w_xfer, w_xfer_last;

   assign load_ready   = ~r_full[r_wr_sel];
   assign w_capture    = ofm_load & load_ready & ~start;
   assign out_valid    = (r_state == ST_STREAM);
   assign w_xfer       = out_valid & out_ready & ~start;
   assign w_xfer_last  = w_xfer & (r_beat == LAST_BEAT);
   // The read bank is full while streaming, so it can never be overwritten
   // under a presented beat; gating with out_valid keeps idle output at zero.
   assign out_data     = out_valid ? r_bank[r_rd_sel][r_beat] : '0;
   assign out_last     = out_valid & (r_beat == LAST_BEAT);
   assign out_tile_idx = r_tile;
   assign job_done     = r_job_done;
   assign overflow_err = r_overflow_err;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_full_cap = r_full;
      if (w_capture) w_full_cap[r_wr_sel] = 1'b1;
      w_full_nxt = w_full_cap;
      if (w_xfer_last) w_full_nxt[r_rd_sel] = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_full_cap[r_rd_sel]) w_state_nxt = ST_STREAM;
         ST_STREAM: if (w_xfer_last)
                       w_state_nxt = w_full_cap[~r_rd_sel] ? ST_STREAM : ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
      if (start) w_state_nxt = ST_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full         <= '0;
         r_wr_sel       <= 1'b0;
         r_rd_sel       <= 1'b0;
         r_beat         <= '0;
         r_tile         <= '0;
         r_job_done     <= 1'b0;
         r_overflow_err <= 1'b0;
      end else if (start) begin
         r_full         <= '0;
         r_wr_sel       <= 1'b0;
         r_rd_sel       <= 1'b0;
         r_beat         <= '0;
         r_tile         <= '0;
         r_job_done     <= 1'b0;
         r_overflow_err <= 1'b0;
      end else begin
         r_full     <= w_full_nxt;
         r_job_done <= w_xfer_last & (r_tile == LAST_TILE);
         if (w_capture) r_wr_sel <= ~r_wr_sel;
         if (ofm_load & ~load_ready) r_overflow_err <= 1'b1;
         if (w_xfer_last) begin
            r_rd_sel <= ~r_rd_sel;
            r_beat   <= '0;
            r_tile   <= (r_tile == LAST_TILE) ? '0 : r_tile + 1'b1;
         end else if (w_xfer) begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   // NOTE: bank storage has no reset; the full flags alone say whether its
   // contents are meaningful, and leaving it out keeps it a plain register file.
   always_ff @(posedge clk) begin
      if (w_capture) r_bank[r_wr_sel] <= ofm_in;
   end

endmodule
